// File: rtl/pc_hazard_ctrl.sv
// pc_hazard_ctrl: fetch-stage control and ID/EX bubble generation from decode and hazard info.
// Detects load-use and branch-operand hazards, sequences 2-cycle stalls, and redirects fetch.
module pc_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_stall,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic             id_is_jump,
    input  logic             id_is_jr,
    input  logic             id_br_taken,
    input  logic             ex_regwr,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_load,
    input  logic [REG_W-1:0] mem_rd,
    output logic             PCWr,
    output logic             IRWrite,
    output logic [1:0]       PCSrc,
    output logic             KILL,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1} state_t;

    state_t state, state_nxt;
    logic   ctl, m_ex, m_mem, h1, h2, stall, flush, run;

    // R0 is hardwired zero, so it never carries a dependence.
    function automatic logic hit(input logic vld, input logic use_r,
                                 input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
        return vld & use_r & (src != '0) & (src == dst);
    endfunction

    always_comb begin
        ctl         = id_is_branch | id_is_jr;
        m_ex        = hit(id_valid, id_use_rs, id_rs, ex_rd) | hit(id_valid, id_use_rt, id_rt, ex_rd);
        m_mem       = hit(id_valid, id_use_rs, id_rs, mem_rd) | hit(id_valid, id_use_rt, id_rt, mem_rd);
        h2          = ctl & m_ex & ex_load;
        h1          = (~ctl & m_ex & ex_load) | (ctl & m_ex & ex_regwr & ~ex_load) | (ctl & m_mem & mem_load);
        stall       = ~reset & ~ext_stall & ((state == HOLD) | ((state == RUN) & (h1 | h2)));
        flush       = ~reset & ~ext_stall & (state == RUN) & ~h1 & ~h2 &
                      ((id_is_branch & id_br_taken) | id_is_jump | id_is_jr);
        run         = ~reset & ~ext_stall & ~stall;
        PCWr        = run;
        IRWrite     = run;
        KILL        = flush;
        PCSrc       = flush ? (id_is_jr ? 2'd2 : 2'd1) : 2'd0;
        idex_bubble = stall;
        // Illegal encodings fall back to RUN even while frozen.
        state_nxt   = (state != RUN && state != HOLD) ? RUN :
                      ext_stall                       ? state :
                      (state == RUN && h2)            ? HOLD : RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// tb_pc_hazard_ctrl: table-driven vectors plus hand sequences for HOLD, freeze, reset and saturation.
module tb_pc_hazard_ctrl;
    localparam int CW = 4;
    localparam logic [5:0] NRM = 6'b11_00_0_0;
    localparam logic [5:0] STL = 6'b00_00_0_1;
    localparam logic [5:0] OFF = 6'b00_00_0_0;
    localparam logic [5:0] RD1 = 6'b11_01_1_0;
    localparam logic [5:0] RD2 = 6'b11_10_1_0;

    logic          clk = 1'b0;
    logic          reset, ext_stall, id_valid, id_use_rs, id_use_rt;
    logic          id_is_branch, id_is_jump, id_is_jr, id_br_taken;
    logic          ex_regwr, ex_load, mem_load;
    logic [4:0]    id_rs, id_rt, ex_rd, mem_rd;
    logic          PCWr, IRWrite, KILL, idex_bubble;
    logic [1:0]    PCSrc;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic       es, v, urs, urt, br, j, jr, tk, exw, exl, ml;
        logic [4:0] rs, rt, exrd, mrd;
        logic [5:0] exp;
    } vec_t;

    vec_t          tbl[17];
    logic [5:0]    q[$];
    logic [CW-1:0] m_stall, m_flush;
    int            tests = 0, fails = 0, idx = 0;

    always #5 clk = ~clk;

    pc_hazard_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .id_is_jr(id_is_jr),
        .id_br_taken(id_br_taken), .ex_regwr(ex_regwr), .ex_load(ex_load), .ex_rd(ex_rd),
        .mem_load(mem_load), .mem_rd(mem_rd), .PCWr(PCWr), .IRWrite(IRWrite), .PCSrc(PCSrc),
        .KILL(KILL), .idex_bubble(idex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic vec_t mk(input logic es, v, input logic [4:0] rs, rt, input logic urs, urt,
                                br, j, jr, tk, exw, exl, input logic [4:0] exrd,
                                input logic ml, input logic [4:0] mrd, input logic [5:0] exp);
        vec_t x;
        x.es = es; x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
        x.br = br; x.j = j; x.jr = jr; x.tk = tk; x.exw = exw; x.exl = exl;
        x.exrd = exrd; x.ml = ml; x.mrd = mrd; x.exp = exp;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s step %0d: got %h, required %h", nm, idx, act, req);
        end
    endtask

    task automatic apply(input vec_t x);
        ext_stall = x.es; id_valid = x.v; id_rs = x.rs; id_rt = x.rt;
        id_use_rs = x.urs; id_use_rt = x.urt; id_is_branch = x.br; id_is_jump = x.j;
        id_is_jr = x.jr; id_br_taken = x.tk; ex_regwr = x.exw; ex_load = x.exl;
        ex_rd = x.exrd; mem_load = x.ml; mem_rd = x.mrd;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input vec_t x);
        logic [5:0] e;
        idx++;
        apply(x);
        q.push_back(x.exp);
        @(negedge clk);
        e = q.pop_front();
        chk("ctl{PCWr,IRWrite,PCSrc,KILL,bubble}", {10'd0, PCWr, IRWrite, PCSrc, KILL, idex_bubble}, {10'd0, e});
        if (e[0] && m_stall != '1) m_stall++;
        if (e[1] && m_flush != '1) m_flush++;
        @(posedge clk);
        #1;
        chk("stall_cnt", 16'(stall_cnt), 16'(m_stall));
        chk("flush_cnt", 16'(flush_cnt), 16'(m_flush));
    endtask

    initial begin
        vec_t h2v, jmp, jmp_es, idle;
        //              es v  rs rt urs urt br j jr tk exw exl exrd ml mrd exp
        tbl[0]  = mk(0, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM);
        tbl[1]  = mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, STL);
        tbl[2]  = mk(0, 1, 1, 4, 0, 1, 0, 0, 0, 0, 1, 1, 4, 0, 0, STL);
        tbl[3]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, NRM);
        tbl[4]  = mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, NRM);
        tbl[5]  = mk(0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, NRM);
        tbl[6]  = mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, NRM);
        tbl[7]  = mk(0, 1, 7, 0, 1, 0, 0, 0, 1, 0, 1, 0, 7, 0, 0, STL);
        tbl[8]  = mk(0, 1, 5, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 5, STL);
        tbl[9]  = mk(0, 1, 5, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 5, RD1);
        tbl[10] = mk(0, 1, 5, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NRM);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, RD1);
        tbl[12] = mk(0, 1, 7, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, RD2);
        tbl[13] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, OFF);
        tbl[14] = mk(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, OFF);
        tbl[15] = mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, NRM);
        tbl[16] = mk(0, 1, 3, 0, 1, 0, 0, 1, 0, 0, 1, 1, 3, 0, 0, STL);
        h2v    = mk(0, 1, 5, 0, 1, 0, 1, 0, 0, 1, 1, 1, 5, 0, 0, STL);
        jmp    = tbl[11];
        jmp_es = tbl[13];
        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM);

        reset = 1'b1;
        apply(jmp);
        m_stall = '0;
        m_flush = '0;
        #2;
        chk("reset ctl", {10'd0, PCWr, IRWrite, PCSrc, KILL, idex_bubble}, 16'd0);
        chk("reset stall_cnt", 16'(stall_cnt), 16'd0);
        chk("reset flush_cnt", 16'(flush_cnt), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) step(tbl[i]);

        // Branch on a load result: two stalls, then the taken branch redirects.
        step(h2v);
        step(mk(0, 1, 5, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 5, STL));
        step(mk(0, 1, 5, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, RD1));
        step(idle);

        // Freeze while in HOLD: nothing moves, exactly one stall remains afterwards.
        step(h2v);
        repeat (3) step(jmp_es);
        step(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL));
        step(jmp);

        // Reset while in HOLD returns to RUN with cleared counters.
        step(h2v);
        idx++;
        reset = 1'b1;
        apply(jmp);
        #1;
        chk("reset-in-HOLD ctl", {10'd0, PCWr, IRWrite, PCSrc, KILL, idex_bubble}, 16'd0);
        chk("reset-in-HOLD stall_cnt", 16'(stall_cnt), 16'd0);
        chk("reset-in-HOLD flush_cnt", 16'(flush_cnt), 16'd0);
        m_stall = '0;
        m_flush = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(jmp);

        // Counters saturate at all-ones.
        repeat (20) step(tbl[1]);
        chk("stall_cnt saturated", 16'(stall_cnt), 16'((1 << CW) - 1));
        repeat (20) step(jmp);
        chk("flush_cnt saturated", 16'(flush_cnt), 16'((1 << CW) - 1));
        step(tbl[1]);
        chk("stall_cnt held at max", 16'(stall_cnt), 16'((1 << CW) - 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
